// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port,
// with per-owner burst locking and full-flag back-pressure.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BITS  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_data,
  input  logic                        fifo_full,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        fifo_wen,
  output logic [NUM_BITS-1:0]         fifo_data,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic [15:0]                 words_written
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] burst_cnt;
  logic [PW-1:0] pick;
  logic          pick_vld;
  logic [PW-1:0] rr_next;
  int            j;

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick     = PW'(j);
      end
    end
  end

  assign rr_next = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    gnt = '0;
    if (!rst && !fifo_full) begin
      if (state == IDLE) begin
        if (pick_vld) gnt[pick] = 1'b1;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  assign fifo_wen = |gnt;

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_data = fifo_data | req_data[i*NUM_BITS +: NUM_BITS];
    end
  end

  assign busy = !rst && (state == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      burst_cnt     <= '0;
      words_written <= '0;
    end else begin
      if (fifo_wen) words_written <= words_written + 16'd1;
      unique case (state)
        IDLE: begin
          if (fifo_wen) begin
            owner  <= pick;
            rr_ptr <= rr_next;
            if (BURST_LEN > 1) begin
              burst_cnt <= CW'(1);
              state     <= BURST;
            end
          end
        end
        BURST: begin
          if (!req[owner]) begin
            burst_cnt <= '0;
            state     <= IDLE;
          end else if (!fifo_full) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt + 1'b1 == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random + directed scoreboard bench for
// fifo_wr_arbiter against a queue-driven reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   gnt;
  logic           fifo_wen;
  logic [W-1:0]   fifo_data;
  logic           busy;
  logic [1:0]     owner;
  logic [15:0]    words_written;

  logic [N-1:0]   req2 = 4'b1001;
  logic           full2 = 1'b0;
  logic [N-1:0]   gnt1;
  logic           wen1;
  logic [W-1:0]   data1;
  logic           busy1;
  logic [1:0]     owner1;
  logic [15:0]    ww1;

  logic [5:0] seq [N];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {2'(i), seq[i]};
  end

  fifo_wr_arbiter #(.NUM_REQ(N), .NUM_BITS(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .fifo_full(fifo_full), .gnt(gnt), .fifo_wen(fifo_wen),
    .fifo_data(fifo_data), .busy(busy), .owner(owner),
    .words_written(words_written)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .NUM_BITS(W), .BURST_LEN(1)) u1 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data),
    .fifo_full(full2), .gnt(gnt1), .fifo_wen(wen1),
    .fifo_data(data1), .busy(busy1), .owner(owner1),
    .words_written(ww1)
  );

  typedef struct {
    bit          wen;
    int          idx;
    logic [W-1:0] data;
    bit          known;
    bit          busy;
    int          own;
    int          ww;
  } exp_t;

  exp_t sq[$];
  int   seen[$];
  int   checks = 0;
  int   errors = 0;

  int   lock = -1;
  int   used = 0;
  int   rr = 0;
  int   own = 0;
  int   ww = 0;
  bit   known = 1'b0;
  int   pend = -1;

  int ord1[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  int ord2[7]  = '{1,1,1,1,2,3,3};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: one call = one clock cycle of stimulus
  task automatic cyc(input bit r, input logic [N-1:0] rq, input bit f);
    exp_t e;
    int   g;
    @(negedge clk);
    if (pend >= 0) seq[pend] = seq[pend] + 6'd1;
    pend = -1;
    rst = r;
    req = rq;
    fifo_full = f;
    e.wen = 1'b0;
    e.idx = 0;
    e.data = '0;
    e.known = known;
    e.busy = !r && (lock >= 0);
    e.own = own;
    e.ww = ww;
    if (r) begin
      lock = -1; used = 0; rr = 0; own = 0; ww = 0; known = 1'b1;
    end else begin
      g = -1;
      if (lock < 0) begin
        if (!f) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && rq[(rr + k) % N]) g = (rr + k) % N;
          end
        end
        if (g >= 0) begin
          own = g;
          rr = (g + 1) % N;
          if (BL > 1) begin
            lock = g;
            used = 1;
          end
        end
      end else if (!rq[lock]) begin
        lock = -1;
        used = 0;
      end else if (!f) begin
        g = lock;
        used++;
        if (used == BL) lock = -1;
      end
      if (g >= 0) begin
        e.wen = 1'b1;
        e.idx = g;
        e.data = {2'(g), seq[g]};
        ww = (ww + 1) % 65536;
        pend = g;
      end
    end
    sq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   di;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() == 0) continue;
      e = sq.pop_front();
      chk("gnt", 32'(gnt), e.wen ? (32'd1 << e.idx) : 32'd0);
      chk("wen", 32'(fifo_wen), 32'(e.wen));
      chk("data", 32'(fifo_data), 32'(e.data));
      chk("busy", 32'(busy), 32'(e.busy));
      if (e.known) begin
        chk("owner", 32'(owner), 32'(e.own));
        chk("words", 32'(words_written), 32'(e.ww));
      end
      if (fifo_wen) begin
        di = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) di = i;
        seen.push_back(di);
      end
    end
  end

  initial begin : monitor_bl1
    int r2;
    int g2;
    r2 = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("bl1_gnt_rst", 32'(gnt1), 32'd0);
        r2 = 0;
      end else begin
        g2 = -1;
        for (int k = 0; k < N; k++) begin
          if (g2 < 0 && req2[(r2 + k) % N]) g2 = (r2 + k) % N;
        end
        chk("bl1_gnt", 32'(gnt1), 32'd1 << g2);
        chk("bl1_data", 32'(data1), 32'(req_data[g2*W +: W]));
        chk("bl1_busy", 32'(busy1), 32'd0);
        r2 = (g2 + 1) % N;
      end
    end
  end

  initial begin : driver
    int base;
    for (int i = 0; i < N; i++) seq[i] = 6'd0;

    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    base = seen.size();
    for (int i = 0; i < 17; i++) cyc(1'b0, 4'b1111, 1'b0);
    #3;
    chk("burst_count", 32'(seen.size() - base), 32'd17);
    for (int i = 0; i < 17; i++)
      if (base + i < seen.size())
        chk("burst_order", 32'(seen[base + i]), 32'(ord1[i]));

    cyc(1'b1, 4'b0000, 1'b0);
    base = seen.size();
    cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0110, 1'b0);
    cyc(1'b0, 4'b1001, 1'b0);
    cyc(1'b0, 4'b1001, 1'b0);
    cyc(1'b0, 4'b1001, 1'b0);
    #3;
    chk("bp_count", 32'(seen.size() - base), 32'd7);
    for (int i = 0; i < 7; i++)
      if (base + i < seen.size())
        chk("bp_order", 32'(seen[base + i]), 32'(ord2[i]));

    cyc(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, 4'($urandom),
          $urandom_range(0, 3) == 0);
    end
    cyc(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    #4;
    chk("drain", 32'(sq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one fifo write port among NUM_REQ producers. The arbiter grants one requester at a time and can lock the grant for a burst of up to BURST_LEN consecutive words. It honours the FIFO's full flag, so no word is ever lost or duplicated. It sits directly in front of the fifo block: it drives wen/data_in and watches full.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_BITS, 8, data word width; matches the fifo NUM_BITS
BURST_LEN, 4, max consecutive words granted to one owner before rotation (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request; bit i = requester i
req_data  input  NUM_REQ*NUM_BITS  flattened data; requester i at bits [i*NUM_BITS +: NUM_BITS]
fifo_full  input  1  full flag from the fifo
gnt  output  NUM_REQ  one-hot (or zero) grant; req[i]&gnt[i] = word i transferred at this edge
fifo_wen  output  1  write enable to the fifo; equals |gnt
fifo_data  output  NUM_BITS  req_data slice of the granted requester; 0 when no grant
busy  output  1  1 while in BURST state
owner  output  clog2(NUM_REQ)  registered index of the current/last owner
words_written  output  16  count of words transferred; wraps 65535->0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, words_written=0.
- While rst=1: gnt=0, fifo_wen=0, fifo_data=0, busy=0.
- Reset mid-burst aborts the burst. No write occurs in the reset cycle.
- gnt, fifo_wen and fifo_data are combinational from the current state and inputs. There is zero latency: a word is written into the fifo on the same edge the grant is seen.
- gnt is always 0 when fifo_full=1. This holds in every state.
- IDLE:
  - If fifo_full=1 or req=0: no grant, stay IDLE.
  - Otherwise, scan from rr_ptr upward modulo NUM_REQ. The first i with req[i]=1 gets gnt[i]=1.
  - At the edge: owner<=i, rr_ptr<=(i+1) mod NUM_REQ.
  - If BURST_LEN>1: burst_cnt<=1 and go to BURST. Otherwise stay IDLE.
- BURST (owner holds the lock):
  - If req[owner]=1 and fifo_full=0: gnt[owner]=1 and burst_cnt<=burst_cnt+1. If burst_cnt+1==BURST_LEN, go to IDLE at the edge.
  - If req[owner]=1 and fifo_full=1: stall. gnt=0, stay BURST, burst_cnt holds. Other requesters are not served.
  - If req[owner]=0: gnt=0 this cycle and go to IDLE (one bubble cycle). burst_cnt<=0.
- rr_ptr updates only on an IDLE grant. Burst continuation does not move it.
- words_written increments by 1 on every edge with fifo_wen=1. It is 16-bit modular.
- Fairness bound: with all requesters active and no full, each requester waits at most (NUM_REQ-1)*BURST_LEN transfers between its bursts.
- Producers must hold req and req_data stable until granted. Dropping req before grant is legal; no grant results.
- Widths: rr_ptr, owner are clog2(NUM_REQ) bits; burst_cnt is clog2(BURST_LEN)+1 bits.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, fifo_wen=0, words_written=0. Release; next cycle gnt=4'b0001, busy goes 1 after the edge.
- Full burst, all requesting, BURST_LEN=4, fifo_full=0, data_i=8'h10+i:
  - Required order: 4x 8'h10, 4x 8'h11, 4x 8'h12, 4x 8'h13, then 8'h10 again.
  - After 16 writes, words_written=16.
- Back-pressure: mid-burst after 2 words of requester 1, hold fifo_full=1 for 3 cycles -> gnt=0 for those 3 cycles, busy=1, burst_cnt=2 held. After release, exactly 2 more words from requester 1, then rotation to requester 2.
- Early release: requester 2 drops req after 1 word -> one bubble cycle with fifo_wen=0, state IDLE. The next grant goes to requester 3 if requesting, else to the first requester found from rr_ptr=3.
- Sparse rotation: req=4'b1001 only, BURST_LEN=1 -> grants alternate 0,3,0,3. busy stays 0.
- Integration: instantiate with fifo depth 8 and drive 12 words -> fifo_wen stops at full (counter=8). After 4 pops, 4 more writes occur. Popped data matches arbitration order with no loss or duplication.
